// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial operand feeder: takes (a, b, len) words over valid/ready and
// emits them LSB-first with vld/last framing, with a one-word pending buffer.
module serial_operand_serializer #(
    parameter int W  = 8,
    parameter int LW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [LW-1:0] in_len,
    output logic          out_vld,
    output logic          out_a,
    output logic          out_b,
    output logic          out_last,
    output logic          busy
);

    // Handshake: a word transfers on the rising edge where in_vld && in_rdy.
    // in_rdy depends only on the pending-buffer flag, never on in_vld.
    logic          out_vld_q, out_vld_d;
    logic          out_a_q, out_a_d;
    logic          out_b_q, out_b_d;
    logic          out_last_q, out_last_d;
    logic [W-1:0]  sh_a_q, sh_a_d;
    logic [W-1:0]  sh_b_q, sh_b_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          pend_full_q, pend_full_d;
    logic [W-1:0]  pend_a_q, pend_a_d;
    logic [W-1:0]  pend_b_q, pend_b_d;
    logic [LW-1:0] pend_len_q, pend_len_d;

    logic          xfer;
    logic          shifting;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic [LW-1:0] src_len;

    assign in_rdy   = rst & ~pend_full_q;
    assign xfer     = in_vld & in_rdy;
    assign shifting = out_vld_q & ~out_last_q;

    // The pending word always has precedence over a word arriving this edge.
    assign src_a   = pend_full_q ? pend_a_q   : in_a;
    assign src_b   = pend_full_q ? pend_b_q   : in_b;
    assign src_len = pend_full_q ? pend_len_q : in_len;

    always_comb begin
        out_vld_d   = out_vld_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_last_d  = out_last_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        cnt_d       = cnt_q;
        pend_full_d = pend_full_q;
        pend_a_d    = pend_a_q;
        pend_b_d    = pend_b_q;
        pend_len_d  = pend_len_q;

        if (shifting) begin
            out_a_d    = sh_a_q[0];
            out_b_d    = sh_b_q[0];
            out_last_d = (cnt_q == LW'(1));
            sh_a_d     = sh_a_q >> 1;
            sh_b_d     = sh_b_q >> 1;
            cnt_d      = cnt_q - LW'(1);
            if (xfer) begin
                pend_full_d = 1'b1;
                pend_a_d    = in_a;
                pend_b_d    = in_b;
                pend_len_d  = in_len;
            end
        end else if (pend_full_q || xfer) begin
            out_vld_d  = 1'b1;
            out_a_d    = src_a[0];
            out_b_d    = src_b[0];
            out_last_d = (src_len == '0);
            sh_a_d     = src_a >> 1;
            sh_b_d     = src_b >> 1;
            cnt_d      = src_len;
            // A word arriving while the pending word is loaded refills the buffer.
            pend_full_d = pend_full_q & xfer;
            if (pend_full_q && xfer) begin
                pend_a_d   = in_a;
                pend_b_d   = in_b;
                pend_len_d = in_len;
            end
        end else begin
            out_vld_d  = 1'b0;
            out_a_d    = 1'b0;
            out_b_d    = 1'b0;
            out_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld_q   <= 1'b0;
            out_a_q     <= 1'b0;
            out_b_q     <= 1'b0;
            out_last_q  <= 1'b0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            cnt_q       <= '0;
            pend_full_q <= 1'b0;
            pend_a_q    <= '0;
            pend_b_q    <= '0;
            pend_len_q  <= '0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_last_q  <= out_last_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            cnt_q       <= cnt_d;
            pend_full_q <= pend_full_d;
            pend_a_q    <= pend_a_d;
            pend_b_q    <= pend_b_d;
            pend_len_q  <= pend_len_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_a    = out_a_q;
    assign out_b    = out_b_q;
    assign out_last = out_last_q;
    assign busy     = out_vld_q | pend_full_q;

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed bench for serial_operand_serializer: expected bit triples are queued on
// each transfer and compared against the serial output stream on the falling edge.
module tb_serial_operand_serializer;

    localparam int W  = 8;
    localparam int LW = $clog2(W);

    logic          clk;
    logic          rst;
    logic          in_vld;
    logic          in_rdy;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [LW-1:0] in_len;
    logic          out_vld;
    logic          out_a;
    logic          out_b;
    logic          out_last;
    logic          busy;

    serial_operand_serializer #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .in_a(in_a), .in_b(in_b), .in_len(in_len),
        .out_vld(out_vld), .out_a(out_a), .out_b(out_b), .out_last(out_last),
        .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [2:0] exp_q[$];      // {a, b, last}
    int tests     = 0;
    int fails     = 0;
    int mon_tests = 0;
    int mon_fails = 0;
    int run_len   = 0;
    int last_run  = 0;
    int wait_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [2:0] e;
        if (rst) begin
            if (out_vld) begin
                run_len = run_len + 1;
                mon_tests++;
                if (exp_q.size() == 0) begin
                    mon_fails++;
                    $error("FAIL stream_extra: observed %b expected none", {out_a, out_b, out_last});
                end else begin
                    e = exp_q.pop_front();
                    assert ({out_a, out_b, out_last} === e) else begin
                        mon_fails++;
                        $error("FAIL stream_bit: observed %b expected %b", {out_a, out_b, out_last}, e);
                    end
                end
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
                mon_tests++;
                assert ({out_a, out_b, out_last} === 3'b000) else begin
                    mon_fails++;
                    $error("FAIL idle_zero: observed %b expected 000", {out_a, out_b, out_last});
                end
            end
        end else begin
            run_len = 0;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 just after the transfer edge, in_vld left high.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [LW-1:0] len);
        logic ok;
        int budget;
        in_vld = 1'b1;
        in_a   = a;
        in_b   = b;
        in_len = len;
        budget = 0;
        wait_cnt = 0;
        do begin
            ok = in_rdy;
            if (ok) begin
                for (int i = 0; i <= int'(len); i++)
                    exp_q.push_back({a[i], b[i], (i == int'(len))});
            end
            @(posedge clk);
            #1;
            wait_cnt++;
            budget++;
        end while (!ok && budget < 100);
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        in_vld = 1'b0;
        in_a   = $urandom_range(0, 255);
        in_b   = $urandom_range(0, 255);
        in_len = LW'($urandom_range(0, W - 1));
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain;
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || busy) && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst    = 1'b0;
        in_vld = 1'b0;
        in_a   = '0;
        in_b   = '0;
        in_len = '0;
        #2;
        check("reset_in_rdy", 32'(in_rdy), 32'd0);
        check("reset_out", 32'({out_vld, out_a, out_b, out_last, busy}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_rdy", 32'(in_rdy), 32'd1);

        // 1. single full-width word; downstream sum 0x96+0x5A = 0xF0
        send(8'h96, 8'h5A, 3'd7);
        check("single_lat_vld", 32'(out_vld), 32'd1);
        check("single_bit0", 32'({out_a, out_b, out_last}), 32'b000);
        idle(1);
        drain();
        idle(2);

        // 2. three words back-to-back with in_vld held
        send(8'h03, 8'h01, 3'd1);
        send(8'hFF, 8'h01, 3'd7);
        send(8'h01, 8'h01, 3'd0);
        check("stream_pend_rdy", 32'(in_rdy), 32'd0);
        check("stream_busy", 32'(busy), 32'd1);
        idle(1);
        drain();
        idle(2);
        check("stream_run_len", 32'(last_run), 32'd11);

        // 3. back-pressure while pending is full
        send(8'hA5, 8'h3C, 3'd7);
        send(8'h5A, 8'hC3, 3'd7);
        check("bp_rdy_low", 32'(in_rdy), 32'd0);
        send(8'h71, 8'h0E, 3'd2);
        check("bp_wait_edges", 32'(wait_cnt), 32'd8);
        idle(1);
        drain();
        idle(2);

        // 4. length boundaries
        send(8'h01, 8'h01, 3'd0);
        check("len0_vld_last", 32'({out_vld, out_last}), 32'b11);
        idle(1);
        check("len0_one_cycle", 32'(out_vld), 32'd0);
        send(8'h80, 8'h00, 3'd7);
        idle(1);
        drain();
        idle(2);

        // 5. async reset mid-word with pending full
        send(8'hF0, 8'h0F, 3'd7);
        send(8'h33, 8'hCC, 3'd7);
        idle(2);
        rst = 1'b0;
        #1;
        check("rst_async_out", 32'({out_vld, out_a, out_b, out_last}), 32'd0);
        check("rst_in_rdy", 32'(in_rdy), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy_clear", 32'(busy), 32'd0);
        send(8'h2D, 8'hB4, 3'd4);
        idle(1);
        drain();
        idle(2);

        // 6. idle gaps of three cycles between words
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] ra, rb;
            logic [LW-1:0] rl;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rl = LW'($urandom_range(0, W - 1));
            send(ra, rb, rl);
            check("gap_latency", 32'({out_vld, out_a, out_b}), 32'({1'b1, ra[0], rb[0]}));
            idle(int'(rl));
            idle(3);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests + mon_tests, fails + mon_fails);
        $finish;
    end

endmodule
